if_stage: RTL

//  Instruction fetch stage; feeds inst_id/pc_id into the decode stage.

---
 rtl/if_stage.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: fetch PC, sync-read instruction RAM, redirect/stall/flush control
// Feeds inst_id/pc_id to decode; the monitor can write the RAM at any time.

module if_stage #(
    parameter int          IWIDTH = 12,
    parameter logic [31:0] NOP    = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_start,
    input  logic [29:0]       start_adr,
    input  logic              jmp_condition_ex,
    input  logic [29:0]       jmp_adr_ex,
    input  logic              stall,
    input  logic              rst_pipe,
    input  logic [IWIDTH-1:0] i_ram_wadr,
    input  logic [31:0]       i_ram_wdata,
    input  logic              i_ram_wen,
    output logic [31:0]       inst_id,
    output logic [29:0]       pc_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state;
    logic [29:0] r_pc_if;
    logic [29:0] r_pc_id;
    logic [31:0] r_hold_buf;
    logic        r_hold_vld;
    logic        r_jmp_pend;
    logic [29:0] r_jmp_pend_adr;

    logic [31:0] r_mem [2**IWIDTH];
    logic [31:0] r_rdata;
    logic [IWIDTH-1:0] w_raddr;

    // Upper PC bits are dropped, so fetch wraps within the RAM.
    assign w_raddr = r_pc_if[IWIDTH-1:0];

    // Read-before-write: a same-address write returns the old word.
    always_ff @(posedge clk) begin
        if (i_ram_wen)
            r_mem[i_ram_wadr] <= i_ram_wdata;
        r_rdata <= r_mem[w_raddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pc_if        <= '0;
            r_pc_id        <= '0;
            r_hold_buf     <= NOP;
            r_hold_vld     <= 1'b0;
            r_jmp_pend     <= 1'b0;
            r_jmp_pend_adr <= '0;
        end else if (rst_pipe) begin
            r_state        <= IDLE;
            r_pc_if        <= '0;
            r_pc_id        <= '0;
            r_hold_buf     <= NOP;
            r_hold_vld     <= 1'b0;
            r_jmp_pend     <= 1'b0;
            r_jmp_pend_adr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cpu_start) begin
                        r_pc_if <= start_adr;
                        r_state <= FILL;
                    end
                end
                FILL: begin
                    if (!stall) begin
                        r_pc_id <= r_pc_if;
                        r_pc_if <= r_pc_if + 30'd1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (stall) begin
                        r_hold_buf <= r_rdata;
                        r_hold_vld <= 1'b1;
                        r_state    <= HOLD;
                        if (jmp_condition_ex) begin
                            r_jmp_pend     <= 1'b1;
                            r_jmp_pend_adr <= jmp_adr_ex;
                        end
                    end else if (jmp_condition_ex) begin
                        // pc_id takes the stale address; decode purges that slot itself.
                        r_pc_id <= r_pc_if;
                        r_pc_if <= jmp_adr_ex;
                        r_state <= FILL;
                    end else begin
                        r_pc_id <= r_pc_if;
                        r_pc_if <= r_pc_if + 30'd1;
                    end
                end
                HOLD: begin
                    if (stall) begin
                        if (jmp_condition_ex) begin
                            r_jmp_pend     <= 1'b1;
                            r_jmp_pend_adr <= jmp_adr_ex;
                        end
                    end else begin
                        r_hold_vld <= 1'b0;
                        r_jmp_pend <= 1'b0;
                        r_pc_id    <= r_pc_if;
                        if (jmp_condition_ex) begin
                            r_pc_if <= jmp_adr_ex;
                            r_state <= FILL;
                        end else if (r_jmp_pend) begin
                            r_pc_if <= r_jmp_pend_adr;
                            r_state <= FILL;
                        end else begin
                            r_pc_if <= r_pc_if + 30'd1;
                            r_state <= RUN;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        inst_id = NOP;
        if (r_state == RUN)
            inst_id = r_rdata;
        else if (r_state == HOLD && r_hold_vld)
            inst_id = r_hold_buf;
    end

    assign pc_id = r_pc_id;

endmodule
